// File: rtl/pipelined_addsub.sv
// pipelined_addsub: valid/ready add/subtract unit with the carry chain split into one slice per pipeline stage
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             cout,
  output logic             ovf
);
  localparam int SLICE = WIDTH / STAGES;
  logic en;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic [STAGES-1:0] cy_q, cy_d, v_q, v_d;
  logic ovf_q, ovf_d;
  logic [STAGES:0][WIDTH-1:0] a_s, b_s, r_s;
  logic [STAGES:0] cy_s, v_s;
  logic [SLICE:0] sum;
  logic [WIDTH-1:0] r_n;
  always_comb begin
    en = ~v_q[STAGES-1] | out_ready;
    a_s = {a_q, a};
    b_s = {b_q, sub ? ~b : b};
    r_s = {r_q, {WIDTH{1'b0}}};
    cy_s = {cy_q, sub};
    v_s = {v_q, in_valid};
    sum = '0;
    r_n = '0;
    for (int k = 0; k < STAGES; k++) begin
      sum = {1'b0, a_s[k][k*SLICE +: SLICE]} + {1'b0, b_s[k][k*SLICE +: SLICE]} + (SLICE+1)'(cy_s[k]);
      r_n = r_s[k];
      r_n[k*SLICE +: SLICE] = sum[SLICE-1:0];
      a_d[k] = en ? a_s[k] : a_q[k];
      b_d[k] = en ? b_s[k] : b_q[k];
      r_d[k] = en ? r_n : r_q[k];
      cy_d[k] = en ? sum[SLICE] : cy_q[k];
      v_d[k] = en ? v_s[k] : v_q[k];
    end
    ovf_d = en ? (a_s[STAGES-1][WIDTH-1] == b_s[STAGES-1][WIDTH-1]) & (r_n[WIDTH-1] != a_s[STAGES-1][WIDTH-1]) : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      cy_q <= '0;
      v_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      cy_q <= cy_d;
      v_q <= v_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready = en;
  assign out_valid = v_q[STAGES-1];
  assign c = r_q[STAGES-1];
  assign cout = cy_q[STAGES-1];
  assign ovf = ovf_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench for pipelined_addsub at 32/4, 16/2 and 8/1
module tb_pipelined_addsub;
  typedef struct {
    logic [31:0] c;
    logic        co;
    logic        ov;
    int          lat;
    int          t;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, ovf;
  logic [31:0] c;
  logic v16 = 1'b0, s16 = 1'b0, rdy16, ov16v, co16, of16;
  logic [15:0] a16 = '0, b16 = '0, c16;
  logic v8 = 1'b0, s8 = 1'b0, rdy8, ov8v, co8, of8;
  logic [7:0] a8 = '0, b8 = '0, c8;
  exp_t q[$], q16[$], q8[$];
  int cyc = 0, nchk = 0, nfail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .cout(cout), .ovf(ovf));
  pipelined_addsub #(.WIDTH(16), .STAGES(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16), .sub(s16),
    .out_valid(ov16v), .out_ready(1'b1), .c(c16), .cout(co16), .ovf(of16));
  pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8), .sub(s8),
    .out_valid(ov8v), .out_ready(1'b1), .c(c8), .cout(co8), .ovf(of8));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y, input logic s, input int t);
    exp_t r;
    logic [32:0] m, bb, sm;
    m = (33'd1 << w) - 33'd1;
    bb = (s ? ~{1'b0, y} : {1'b0, y}) & m;
    sm = ({1'b0, x} & m) + bb + 33'(s);
    r.c = sm[31:0] & m[31:0];
    r.co = sm[w];
    r.ov = (x[w-1] == bb[w-1]) && (r.c[w-1] != x[w-1]);
    r.lat = w / 8 == 1 ? 1 : (w == 16 ? 2 : 4);
    r.t = t;
    return r;
  endfunction
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s, input logic [31:0] ec,
                      input logic eco, input logic eov, input int lat);
    int n = 0;
    a = x;
    b = y;
    sub = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("accept", in_ready, 1'b1);
    if (in_ready) q.push_back('{ec, eco, eov, lat, cyc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() + q16.size() + q8.size()) != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain", q.size() + q16.size() + q8.size(), 0);
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", c, 32'hxxxxxxxx);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("c", c, e.c);
        chk("cout", cout, e.co);
        chk("ovf", ovf, e.ov);
        if (e.lat >= 0) chk("latency", cyc - e.t, e.lat);
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n && ov16v) begin
      if (q16.size() == 0) chk("unexpected_out16", c16, 32'hxxxxxxxx);
      else begin
        exp_t e;
        e = q16.pop_front();
        chk("c16", c16, e.c);
        chk("cout16", co16, e.co);
        chk("ovf16", of16, e.ov);
        chk("latency16", cyc - e.t, e.lat);
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n && ov8v) begin
      if (q8.size() == 0) chk("unexpected_out8", c8, 32'hxxxxxxxx);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("c8", c8, e.c);
        chk("cout8", co8, e.co);
        chk("ovf8", of8, e.ov);
        chk("latency8", cyc - e.t, e.lat);
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_c", c, 32'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send(32'd123, 32'd11, 1'b0, 32'd134, 1'b0, 1'b0, 4);
    drain();
    @(posedge clk);
    #1;
    send(32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 4);
    send(32'd7, 32'd5, 1'b1, 32'd2, 1'b1, 1'b0, 4);
    send(32'hFFFFFFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 4);
    send(32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, 4);
    send(32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 4);
    drain();
    @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 8; i++) send(32'(i), 32'(2 * i), 1'b0, 32'(3 * i), 1'b0, 1'b0, -1);
      begin
        logic [31:0] held;
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = c;
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_in_ready", in_ready, 1'b0);
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 1'b0);
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_c_held", c, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 32'd100;
    b = 32'd1;
    sub = 1'b0;
    @(posedge clk);
    #1;
    a = 32'd200;
    @(posedge clk);
    #1;
    a = 32'd300;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_c", c, 32'h0);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_out", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    send(32'd9, 32'd10, 1'b0, 32'd19, 1'b0, 1'b0, 4);
    drain();
    @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      a16 = 16'($urandom);
      b16 = i == 0 ? 16'h8000 : 16'($urandom);
      s16 = 1'($urandom);
      a8 = i == 0 ? 8'h7F : 8'($urandom);
      b8 = i == 0 ? 8'h01 : 8'($urandom);
      s8 = i == 0 ? 1'b0 : 1'($urandom);
      v16 = 1'b1;
      v8 = 1'b1;
      @(negedge clk);
      chk("rdy16", rdy16, 1'b1);
      chk("rdy8", rdy8, 1'b1);
      q16.push_back(model(16, {16'h0, a16}, {16'h0, b16}, s16, cyc));
      q8.push_back(model(8, {24'h0, a8}, {24'h0, b8}, s8, cyc));
      @(posedge clk);
      #1;
    end
    v16 = 1'b0;
    v8 = 1'b0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
